// File: rtl/sr_cell_writer_pkg.sv
// Shared types and default constants for the SR cell write controller.
package sr_cell_writer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    CLR    = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_SETTLE_CYC = 1;
  localparam int DEF_MAX_RETRY  = 2;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_cell_writer_if.sv
// Request/response port plus SR cell excitation and readback signals.
interface sr_cell_writer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] s_o;
  logic [WIDTH-1:0] r_o;
  logic             resp_valid;
  logic             resp_err;
  logic [WIDTH-1:0] resp_mism;

  modport slave (
    input  req_valid, req_data, cell_q,
    output req_ready, s_o, r_o, resp_valid, resp_err, resp_mism
  );

  modport master (
    output req_valid, req_data, cell_q,
    input  req_ready, s_o, r_o, resp_valid, resp_err, resp_mism
  );
endinterface

// File: rtl/sr_excitation_calc.sv
// Per-bit set/clear masks; a bit can only be in one mask since each term
// requires the opposite polarity of target.
module sr_excitation_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cell_q,
  output logic [WIDTH-1:0] set_mask,
  output logic [WIDTH-1:0] clr_mask
);
  assign set_mask = target & ~cell_q;
  assign clr_mask = ~target & cell_q;
endmodule

// File: rtl/sr_cell_writer.sv
// Write-verify-retry controller for a bank of clocked SR cells.
//   state  | meaning
//   IDLE   | ready for a request; response pulse appears here
//   SET    | drive set pulses, no reset pulses
//   CLR    | drive reset pulses, no set pulses
//   SETTLE | quiet cycles before readback
//   CHECK  | compare cells with target; retry or respond
module sr_cell_writer
  import sr_cell_writer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input logic               clk,
  input logic               rst,
  sr_cell_writer_if.slave   bus
);

  localparam int RW = cnt_width(MAX_RETRY);
  localparam int SW = cnt_width(SETTLE_CYC);
  localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);
  localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? SW'(SETTLE_CYC - 1) : '0;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] clr_mask_q;
  logic [RW-1:0]    retry_cnt;
  logic [SW-1:0]    settle_cnt;

  logic [WIDTH-1:0] calc_target, calc_set, calc_clr;
  logic             accept, cells_match, can_retry;

  // In IDLE the masks come from the incoming word, later from the latched one.
  assign calc_target = (state_q == IDLE) ? bus.req_data : target_q;

  sr_excitation_calc #(.WIDTH(WIDTH)) u_calc (
    .target   (calc_target),
    .cell_q   (bus.cell_q),
    .set_mask (calc_set),
    .clr_mask (calc_clr)
  );

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign cells_match   = (bus.cell_q == target_q);
  assign can_retry     = (retry_cnt < RETRY_LIM);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = SET;
      SET:     state_n = CLR;
      CLR:     state_n = (SETTLE_CYC == 0) ? CHECK : SETTLE;
      SETTLE:  if (settle_cnt == '0) state_n = CHECK;
      CHECK: begin
        if (cells_match)    state_n = IDLE;
        else if (can_retry) state_n = SET;
        else                state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q       <= '0;
      clr_mask_q     <= '0;
      retry_cnt      <= '0;
      settle_cnt     <= '0;
      bus.s_o        <= '0;
      bus.r_o        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_mism  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;

      if (accept) begin
        target_q  <= bus.req_data;
        retry_cnt <= '0;
      end else if (state_q == CHECK && !cells_match && can_retry) begin
        retry_cnt <= retry_cnt + 1'b1;
      end

      // Entering SET happens only on accept or retry, so calc_* is current.
      if (state_n == SET) clr_mask_q <= calc_clr;

      if (state_q == CLR)
        settle_cnt <= SETTLE_LOAD;
      else if (state_q == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 1'b1;

      bus.s_o <= (state_n == SET) ? calc_set : '0;
      bus.r_o <= (state_n == CLR) ? clr_mask_q : '0;

      if (state_q == CHECK && state_n == IDLE) begin
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= !cells_match;
        bus.resp_mism  <= bus.cell_q ^ target_q;
      end
    end
  end

endmodule

// File: tb/tb_sr_cell_writer.sv
// Directed and random bench for sr_cell_writer against a behavioural SR cell bank.
module tb_sr_cell_writer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] cells;
  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] stuck0;

  sr_cell_writer_if #(.WIDTH(8)) bus ();

  sr_cell_writer #(.WIDTH(8), .SETTLE_CYC(1), .MAX_RETRY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Cell bank: set/clear/hold on the clock, with optional stuck-at-0 bits.
  always @(posedge clk) begin
    if (load_en) cells <= load_val & ~stuck0;
    else         cells <= ((cells | bus.s_o) & ~bus.r_o) & ~stuck0;
  end
  assign bus.cell_q = cells;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) chk("s_and_r", 32'(bus.s_o & bus.r_o), 32'd0);

  task automatic load_cells(input logic [7:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(posedge clk);
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  // Issue one request from a negedge; returns at the negedge of the response cycle.
  task automatic write_word(input logic [7:0] tgt, input logic [7:0] exp_s,
                            input logic [7:0] exp_r, input int n_att,
                            input logic exp_err, input logic [7:0] exp_mism,
                            input logic hold, input logic [7:0] next_data);
    int  n = 0;
    bit  got = 0;
    bus.req_valid = 1'b1;
    bus.req_data  = tgt;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_accept", bus.req_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = hold;
        bus.req_data  = next_data;
      end
      if ((k - 1) % 4 == 0 && (k - 1) / 4 < n_att) chk("s_o", bus.s_o, exp_s);
      if (k == 2) chk("r_o", bus.r_o, exp_r);
      if (bus.resp_valid) begin
        got = 1;
        chk("resp_latency", k, 1 + 4 * n_att);
        chk("resp_err", bus.resp_err, exp_err);
        chk("resp_mism", bus.resp_mism, exp_mism);
        chk("req_ready_resp", bus.req_ready, 1);
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] v, t;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    load_en       = 1'b0;
    load_val      = '0;
    stuck0        = '0;

    repeat (3) @(negedge clk);
    chk("rst_s_o", bus.s_o, 0);
    chk("rst_r_o", bus.r_o, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_resp_mism", bus.resp_mism, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);

    // Plain write from all-zero cells
    load_cells(8'h00);
    write_word(8'hA5, 8'hA5, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("cells_a5", cells, 8'hA5);

    // Mixed set and clear
    load_cells(8'hF0);
    write_word(8'h3C, 8'h0C, 8'hC0, 1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("cells_3c", cells, 8'h3C);

    // Stuck bit exhausts retries
    stuck0 = 8'h01;
    load_cells(8'h00);
    write_word(8'h01, 8'h01, 8'h00, 3, 1'b1, 8'h01, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("mism_held", bus.resp_mism, 8'h01);
    chk("resp_pulse_single", bus.resp_valid, 0);
    stuck0 = 8'h00;

    // Back-to-back: second request accepted in the first response cycle
    load_cells(8'h00);
    write_word(8'h12, 8'h12, 8'h00, 1, 1'b0, 8'h00, 1'b1, 8'h34);
    chk("cells_12", cells, 8'h12);
    write_word(8'h34, 8'h24, 8'h02, 1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("cells_34", cells, 8'h34);

    // Reset during CLR
    load_cells(8'hFF);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_s_o", bus.s_o, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("abort_r_o", bus.r_o, 8'hA5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_s_zero", bus.s_o, 0);
    chk("abort_r_zero", bus.r_o, 0);
    chk("abort_ready_low", bus.req_ready, 0);
    chk("abort_no_resp", bus.resp_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready_high", bus.req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_quiet", bus.resp_valid, 0);
      @(negedge clk);
    end
    load_cells(8'h00);
    write_word(8'hC3, 8'hC3, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("cells_c3", cells, 8'hC3);

    // Random targets over random initial cell states
    for (int i = 0; i < 1000; i++) begin
      v = 8'($urandom_range(0, 255));
      t = (i % 8 == 0) ? v : 8'($urandom_range(0, 255));
      load_cells(v);
      write_word(t, t & ~v, ~t & v, 1, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("rand_cells", cells, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_cell_writer.md
# sr_cell_writer

Write controller for a bank of WIDTH clocked SR storage cells. It accepts a target word over a valid/ready request port and compares it with the cells' current outputs. It then drives per-bit set and reset excitation pulses, with a set phase and then a reset phase, and never asserts s and r on the same bit. After a settle interval it reads the cells back to verify, retries on mismatch, and reports completion or error. It sits between a register-file or config master and the SR cell array, and it is the writer side of the cell interface.

## Interface
Parameters:
- WIDTH, 8: number of SR cells driven.
- SETTLE_CYC, 1: idle cycles between the reset phase and the readback check (≥0).
- MAX_RETRY, 2: extra write attempts after the first failed check (≥0).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  target word present.
- req_ready  out  1  high only in IDLE.
- req_data  in  WIDTH  target word.
- cell_q  in  WIDTH  cell outputs, synchronous to clk.
- s_o  out  WIDTH  set excitation, registered.
- r_o  out  WIDTH  reset excitation, registered.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = verify failed after all retries.
- resp_mism  out  WIDTH  valid with resp_valid; cell_q XOR target at the final check.

## Operation
- Cell semantics: s=1,r=0 sets the cell; s=0,r=1 clears it; s=r=0 holds. s=r=1 is forbidden, and (s_o & r_o) must be 0 every cycle.
- FSM states: IDLE, SET, CLR, SETTLE, CHECK.
- IDLE: req_ready=1. On req_valid&&req_ready, latch target=req_data and compute set_mask=target&~cell_q and clr_mask=~target&cell_q from cell_q in the accept cycle. Clear retry_cnt. Go to SET.
- SET: s_o=set_mask, r_o=0. Go to CLR.
- CLR: s_o=0, r_o=clr_mask. Go to SETTLE, or to CHECK if SETTLE_CYC=0.
- SETTLE: s_o=r_o=0 for SETTLE_CYC cycles. Go to CHECK.
- CHECK: s_o=r_o=0; compare cell_q with target.
  - Match: register resp_valid=1, resp_err=0, resp_mism=0; go to IDLE.
  - Mismatch with retry_cnt<MAX_RETRY: recompute the masks from the current cell_q, increment retry_cnt, go to SET.
  - Mismatch with retry_cnt==MAX_RETRY: register resp_valid=1, resp_err=1, resp_mism=cell_q^target; go to IDLE.
- Phases are never skipped. A zero mask still occupies its cycle with all-zero pulses.
- A target equal to cell_q yields zero masks and reports success.
- resp_mism is held until the next response. resp_valid is a single-cycle pulse with no backpressure.
- retry_cnt width is $clog2(MAX_RETRY+1), minimum 1.

## Timing
- Reset: s_o=0, r_o=0, req_ready=0 while rst=1, resp_valid=0, resp_err=0, resp_mism=0; state goes to IDLE. req_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation aborts on the next edge. No response is issued, outputs are zero, and the latched target is discarded.
- With the request accepted at edge T and S=SETTLE_CYC:
  - s_o is valid in cycle T+1.
  - r_o is valid in cycle T+2.
  - CHECK samples cell_q in cycle T+3+S.
  - resp_valid is high in cycle T+4+S.
- Each retry adds 3+S cycles. The worst case gives resp_valid at T+1+(MAX_RETRY+1)(3+S).
- resp_valid is high in the IDLE cycle, so a new request can be accepted in the same cycle as the previous response.

## Structure
- Package sr_cell_writer_pkg holds the state enum (IDLE, SET, CLR, SETTLE, CHECK) and the default parameter constants.
- One sub-module, sr_excitation_calc: combinational (target, cell_q) → (set_mask, clr_mask), with the disjointness guaranteed by construction.
- The FSM, counters and output registers live in the top module.

## Test plan
All scenarios use WIDTH=8, SETTLE_CYC=1, MAX_RETRY=2, and a behavioural SR cell-bank model unless stated otherwise.
- Reset, then cell_q=0x00, request 0xA5 at T → s_o=0xA5 at T+1, r_o=0x00 at T+2, resp_valid at T+5 with resp_err=0, resp_mism=0x00.
- cell_q=0xF0, request 0x3C → s_o=0x0C at T+1, r_o=0xC0 at T+2, cells read 0x3C, success at T+5.
- Bit 0 stuck at 0, request 0x01 → s_o=0x01 at T+1, T+5 and T+9; resp_valid at T+13 with resp_err=1, resp_mism=0x01.
- Two back-to-back requests 0x12 then 0x34 with req_valid held → second accepted in the resp_valid cycle of the first; both succeed and cells end at 0x34.
- rst asserted during CLR → s_o=r_o=0 next cycle, no resp_valid, req_ready=1 after deassert, and a new request completes normally.
- 1000 random targets with random initial cell states → (s_o&r_o)==0 every cycle, target==cell_q yields all-zero pulses, and every response is error-free.
